// File: rtl/rr_arbiter128_if.sv
// rr_arbiter128 request/grant bundle.
// Four 32-bit request words in, index and one-hot grant out.
interface rr_arbiter128_if;
    logic [31:0] R3;
    logic [31:0] R2;
    logic [31:0] R1;
    logic [31:0] R0;
    logic        gnt_valid;
    logic [6:0]  G;
    logic [31:0] X3;
    logic [31:0] X2;
    logic [31:0] X1;
    logic [31:0] X0;

    modport master (
        output R3, R2, R1, R0,
        input  gnt_valid, G, X3, X2, X1, X0
    );

    modport slave (
        input  R3, R2, R1, R0,
        output gnt_valid, G, X3, X2, X1, X0
    );
endinterface

// File: rtl/rr_arbiter128.sv
// 128-way round-robin arbiter with optional maximum hold tenure.
// Grant reported as a 7-bit index plus a gated one-hot in four words.
module rr_arbiter128 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input logic            clk,
    input logic            rst_n,
    rr_arbiter128_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } st_t;

    // Expiry compare value; unused when tenure is unlimited.
    localparam logic [CNT_W-1:0] LIM =
        CNT_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);

    st_t              st_q;
    st_t              st_nxt;
    logic [6:0]       g_q;
    logic [6:0]       g_nxt;
    logic [6:0]       last_q;
    logic [6:0]       last_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             vld_q;
    logic             vld_nxt;

    logic [127:0]     req;
    logic             any_req;
    logic             holder_req;
    logic             expire;
    logic [6:0]       start;
    logic [6:0]       win;
    logic [127:0]     onehot;

    // First set bit of r scanning s, s+1, ... with 7-bit wrap.
    function automatic logic [6:0] pick(
        input logic [127:0] r,
        input logic [6:0]   s
    );
        logic [255:0] dbl;
        logic [127:0] rot;
        logic [6:0]   off;
        logic         hit;
        dbl = {r, r} >> s;
        rot = dbl[127:0];
        off = '0;
        hit = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                off = 7'(i);
            end
        end
        return s + off;
    endfunction

    assign req        = {bus.R3, bus.R2, bus.R1, bus.R0};
    assign any_req    = |req;
    assign holder_req = req[g_q];
    assign expire     = (HOLD_MAX != 0) && (cnt_q == LIM);
    assign start      = (st_q == IDLE) ? last_q + 7'd1
                                       : g_q + 7'd1;
    assign win        = pick(req, start);

    // State and holder registers; reset makes the first search start at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            g_q    <= '0;
            last_q <= 7'd127;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            st_q   <= st_nxt;
            g_q    <= g_nxt;
            last_q <= last_nxt;
            cnt_q  <= cnt_nxt;
            vld_q  <= vld_nxt;
        end
    end

    // Grant decision: hold, hand over back-to-back, or drop to idle.
    always_comb begin
        st_nxt   = st_q;
        g_nxt    = g_q;
        last_nxt = last_q;
        cnt_nxt  = cnt_q;
        vld_nxt  = vld_q;
        unique case (st_q)
            IDLE: begin
                if (any_req) begin
                    st_nxt   = GRANT;
                    g_nxt    = win;
                    last_nxt = win;
                    cnt_nxt  = '0;
                    vld_nxt  = 1'b1;
                end
            end
            GRANT: begin
                if (!holder_req || expire) begin
                    if (any_req) begin
                        g_nxt    = win;
                        last_nxt = win;
                        cnt_nxt  = '0;
                    end else begin
                        st_nxt  = IDLE;
                        g_nxt   = '0;
                        cnt_nxt = '0;
                        vld_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                st_nxt  = IDLE;
                g_nxt   = '0;
                cnt_nxt = '0;
                vld_nxt = 1'b0;
            end
        endcase
    end

    // One-hot view of the registered holder, forced to zero when idle.
    assign onehot = vld_q ? (128'd1 << g_q) : '0;

    assign bus.gnt_valid = vld_q;
    assign bus.G         = g_q;
    assign bus.X3        = onehot[127:96];
    assign bus.X2        = onehot[95:64];
    assign bus.X1        = onehot[63:32];
    assign bus.X0        = onehot[31:0];

endmodule

// File: tb/tb_rr_arbiter128.sv
// Bench for rr_arbiter128: three instances (HOLD_MAX 0, 4, 3) share stimulus.
// A reference model queues expected grants; a monitor compares them.
module tb_rr_arbiter128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] req = '0;

    int checks = 0;
    int errors = 0;

    rr_arbiter128_if if0 ();
    rr_arbiter128_if if4 ();
    rr_arbiter128_if if3 ();

    assign if0.R3 = req[127:96];
    assign if0.R2 = req[95:64];
    assign if0.R1 = req[63:32];
    assign if0.R0 = req[31:0];
    assign if4.R3 = req[127:96];
    assign if4.R2 = req[95:64];
    assign if4.R1 = req[63:32];
    assign if4.R0 = req[31:0];
    assign if3.R3 = req[127:96];
    assign if3.R2 = req[95:64];
    assign if3.R1 = req[63:32];
    assign if3.R0 = req[31:0];

    rr_arbiter128 #(.HOLD_MAX(0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    rr_arbiter128 #(.HOLD_MAX(4), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave));
    rr_arbiter128 #(.HOLD_MAX(3), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always #5 clk = ~clk;

    logic         dv [3];
    logic [6:0]   dg [3];
    logic [127:0] dx [3];

    assign dv[0] = if0.gnt_valid;
    assign dv[1] = if4.gnt_valid;
    assign dv[2] = if3.gnt_valid;
    assign dg[0] = if0.G;
    assign dg[1] = if4.G;
    assign dg[2] = if3.G;
    assign dx[0] = {if0.X3, if0.X2, if0.X1, if0.X0};
    assign dx[1] = {if4.X3, if4.X2, if4.X1, if4.X0};
    assign dx[2] = {if3.X3, if3.X2, if3.X1, if3.X0};

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: per instance holder, last winner, cycles held so far.
    int hm    [3] = '{0, 4, 3};
    bit mv    [3];
    int mg    [3];
    int mlast [3];
    int mten  [3];

    logic [23:0] sbq [$];

    function automatic int pickm(input logic [127:0] r, input int s);
        for (int i = 0; i < 128; i++) begin
            if (r[(s + i) % 128]) return (s + i) % 128;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k]    = 1'b0;
            mg[k]    = 0;
            mlast[k] = 127;
            mten[k]  = 0;
        end
        sbq.delete();
    endtask

    task automatic model_step(input int k, input logic [127:0] r);
        int w;
        if (!mv[k]) begin
            if (r != '0) begin
                w        = pickm(r, mlast[k] + 1);
                mv[k]    = 1'b1;
                mg[k]    = w;
                mlast[k] = w;
                mten[k]  = 1;
            end
        end else if (!r[mg[k]] || (hm[k] != 0 && mten[k] == hm[k])) begin
            if (r != '0) begin
                w        = pickm(r, mg[k] + 1);
                mg[k]    = w;
                mlast[k] = w;
                mten[k]  = 1;
            end else begin
                mv[k]   = 1'b0;
                mg[k]   = 0;
                mten[k] = 0;
            end
        end else begin
            mten[k] = mten[k] + 1;
        end
    endtask

    // Model advances on every edge and queues the expected outputs.
    initial begin
        logic [23:0] e;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    model_step(k, req);
                    e[k*8 +: 8] = {mv[k], 7'(mg[k])};
                end
                sbq.push_back(e);
            end
        end
    end

    // Monitor compares the DUT against queued expectations mid-cycle.
    initial begin
        logic [23:0]  e;
        logic         ev;
        logic [6:0]   eg;
        logic [127:0] ex;
        forever begin
            @(negedge clk);
            if (rst_n && sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    ev = e[k*8 + 7];
                    eg = e[k*8 +: 7];
                    ex = '0;
                    if (ev) ex[eg] = 1'b1;
                    chk($sformatf("valid[%0d]", k), 128'(dv[k]), 128'(ev));
                    chk($sformatf("G[%0d]", k), 128'(dg[k]), 128'(eg));
                    chk($sformatf("X[%0d]", k), dx[k], ex);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_clear(input string nm);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_valid[%0d]", nm, k), 128'(dv[k]), '0);
            chk($sformatf("%s_G[%0d]", nm, k), 128'(dg[k]), '0);
            chk($sformatf("%s_X[%0d]", nm, k), dx[k], '0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req   = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk_clear("reset");
        cyc(3);
        req   = '0;
        rst_n = 1'b1;
        cyc(2);

        // Single request, requester 5.
        req = 128'd1 << 5;
        cyc(1);
        chk("single_G", 128'(if0.G), 128'd5);
        chk("single_X0", 128'(if0.X0), 128'h20);
        chk("single_X321", {if0.X3, if0.X2, if0.X1}, '0);
        cyc(19);
        chk("single_hold", 128'(if0.G), 128'd5);
        req = '0;
        cyc(1);
        chk("single_drop", 128'(if0.gnt_valid), '0);
        cyc(2);

        // Rotation among 3, 70, 127.
        req = '0;
        req[3]   = 1'b1;
        req[70]  = 1'b1;
        req[127] = 1'b1;
        cyc(30);

        // Wrap-around: holder 127 releases with 0 and 126 pending.
        req = 128'd1 << 127;
        cyc(3);
        chk("wrap_hold", 128'(if0.G), 128'd127);
        req[0]   = 1'b1;
        req[126] = 1'b1;
        cyc(3);
        req[127] = 1'b0;
        cyc(1);
        chk("wrap_G", 128'(if0.G), 128'd0);
        chk("wrap_X0", 128'(if0.X0), 128'h1);
        cyc(2);

        // Sole requester 64 under expiry.
        req = 128'd1 << 64;
        cyc(12);
        chk("sole_G", 128'(if3.G), 128'd64);
        chk("sole_X2", 128'(if3.X2), 128'h1);
        chk("sole_valid", 128'(if3.gnt_valid), 128'd1);

        // Reset mid-grant.
        req = '0;
        req[70] = 1'b1;
        req[2]  = 1'b1;
        cyc(2);
        chk("mid_G70", 128'(if0.G), 128'd70);
        chk("mid_X2", 128'(if0.X2), 128'h40);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_clear("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("mid_first_G", 128'(if0.G), 128'd2);
        chk("mid_first_X0", 128'(if0.X0), 128'h4);

        // Randomized traffic.
        repeat (600) begin
            if ($urandom_range(3) == 0) begin
                req = '0;
                n = $urandom_range(4);
                for (int j = 0; j < n; j++) begin
                    req[$urandom_range(127)] = 1'b1;
                end
                if ($urandom_range(3) == 0) req[127] = 1'b1;
                if ($urandom_range(3) == 0) req[0] = 1'b1;
            end
            cyc(1);
        end
        req = '0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
